guess_checker: RTL and testbench
================================

# guess_checker

Round-side counterpart of the game logic in the binary number game. Receives round control (`g_enable`, `level`, `time_f`) and produces the game logic's inputs (`cmp_r`, `end_f`). It generates a level-scaled pseudo-random target number, edge-detects the guess button, compares the switch value against the target, and counts remaining attempts. It sits between the switch/button inputs, the display path and the game logic.

## Interface
Parameters:
- `WIDTH`, default 8: target and switch width.
- `MAX_TRIES`, default 3: guesses allowed per round, range 1..3.
- `MAX_LEVEL`, default 8'd15: a correct guess at this level ends the game.
- `LFSR_SEED`, default 8'hA5: LFSR reset value, must be nonzero.

Ports (reset is synchronous, active-high; single clock):
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `g_enable`  in  1  round active, from game logic.
- `level`  in  8  current level, from game logic.
- `time_f`  in  1  round timeout, from game logic.
- `guess_b`  in  1  guess button, already debounced and synchronous.
- `switches`  in  WIDTH  player's binary guess.
- `target`  out  WIDTH  current target number, to display.
- `cmp_r`  out  1  last guess correct.
- `end_f`  out  1  game over, sticky.
- `tries_left`  out  2  remaining attempts.
- `hint_hi`  out  1  last wrong guess was above target; present only with HINT_EN, see Configuration.

## Operation
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every cycle including IDLE, never all-zero.
- Mask: active bits n = min(level,7)+1; mask = (1<<n)-1.
- FSM states: IDLE, LOAD, WAIT, RESULT, OVER.
  - IDLE: waits for a `g_enable` rising edge, then goes to LOAD.
  - LOAD (one cycle): target ← lfsr & mask; tries_left ← MAX_TRIES; cmp_r ← 0; hint_hi ← 0; go to WAIT.
  - WAIT, on a `guess_b` rising edge: cmp_r ← (switches == target).
    - If correct: go to RESULT.
    - If wrong: decrement tries_left (saturating at 0); if it reaches 0, go to OVER; otherwise stay in WAIT.
  - WAIT, on `time_f` = 1: go to OVER.
  - RESULT: if level ≥ MAX_LEVEL, go to OVER. Otherwise hold cmp_r until `g_enable` falls, then go to IDLE.
  - OVER: end_f = 1 and held until `rst`. All further inputs are ignored.
- `g_enable` falling in WAIT: go to IDLE; cmp_r, target and tries_left hold their values.
- Simultaneous guess edge and `time_f` in WAIT: the guess is evaluated first. If correct, go to RESULT; otherwise go to OVER.
- Comparison uses all WIDTH bits. Switch bits above the mask must be 0 for a match.

## Timing
- Reset values: target = 0, cmp_r = 0, end_f = 0, tries_left = 0, hint_hi = 0, FSM = IDLE, LFSR = LFSR_SEED.
- `rst` takes effect on the next edge from any state, including mid-round.
- target and tries_left are valid 2 cycles after the `g_enable` rising edge: edge detect, then LOAD.
- Guess latency: `guess_b` high at cycle N and low at N-1 → cmp_r, tries_left and hint_hi update at N+1. Holding the button produces no further evaluations.
- A guess edge in LOAD or IDLE is ignored.
- end_f asserts one cycle after the triggering event.

## Configuration
- `GUESS_CHECKER_HINT_EN`:
  - Defined: the `hint_hi` port exists. On a wrong guess, hint_hi ← (switches > target), updated with cmp_r and cleared in LOAD.
  - Undefined: the port and the magnitude comparator are absent.

## Structure
- Shared package `spele_pkg`:
  - FSM state enum.
  - LFSR width, taps and default seed.
  - WIDTH and MAX_LEVEL constants, shared with the game logic.
- Sub-module `lfsr8`: free-running LFSR with `clk`, `rst` and a seed parameter, output `q[7:0]`.

## Test plan
- Reset with `rst` = 1 for 2 cycles → all outputs 0, FSM IDLE. Observe `lfsr8` q = 8'hA5 after reset.
- level = 3, `g_enable` 0→1 → at +2 cycles: target ≤ 8'h0F, tries_left = 3, cmp_r = 0.
- In WAIT, switches = target, one `guess_b` pulse → cmp_r = 1 next cycle, tries_left = 3, end_f = 0. Lowering `g_enable` returns the FSM to IDLE.
- Three guesses with switches = target ^ 1 → tries_left 2, 1, 0; cmp_r = 0; end_f = 1 one cycle after the third. A fourth guess changes nothing. With HINT_EN, hint_hi matches the sign of the guess error.
- `time_f` = 1 in WAIT with no guess → end_f = 1 next cycle, cmp_r = 0. A simultaneous correct guess instead gives cmp_r = 1 and end_f = 0.
- level = 15, correct guess → cmp_r = 1, then end_f = 1. Asserting `rst` mid-round from any state returns all outputs to 0.

Source files
------------

// File: rtl/spele_pkg.sv
// Shared definitions for the binary number game: FSM states, LFSR constants,
// game-wide width and level limits, and the level-to-mask helper.
package spele_pkg;

    localparam int          LFSR_W         = 8;
    localparam logic [7:0]  LFSR_TAPS      = 8'hB8;   // x^8+x^6+x^5+x^4+1 -> bits 7,5,4,3
    localparam logic [7:0]  LFSR_SEED_DEF  = 8'hA5;
    localparam int          GAME_WIDTH     = 8;
    localparam logic [7:0]  GAME_MAX_LEVEL = 8'd15;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WAIT   = 3'd2,
        S_RESULT = 3'd3,
        S_OVER   = 3'd4
    } gc_state_e;

    // Target mask with min(level,7)+1 active low-order bits.
    function automatic logic [7:0] level_mask(input logic [7:0] lvl);
        logic [7:0] m;
        if (lvl >= 8'd7) begin
            m = 8'hFF;
        end else begin
            m = (8'd1 << (lvl + 8'd1)) - 8'd1;
        end
        return m;
    endfunction

endpackage

// File: rtl/guess_checker_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (module lfsr8); never reaches all-zero
// as long as SEED is nonzero.
module lfsr8
    import spele_pkg::*;
#(
    parameter logic [7:0] SEED = LFSR_SEED_DEF
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    // Next value: shift left, feed back the XOR of the tapped bits.
    always_comb begin
        q_d = {q_q[6:0], ^(q_q & LFSR_TAPS)};
    end

    // LFSR state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/guess_checker.sv
// Round-side guess checker: level-scaled random target, guess evaluation and
// attempt counting. Optional hint_hi output with GUESS_CHECKER_HINT_EN.
module guess_checker
    import spele_pkg::*;
#(
    parameter int         WIDTH     = GAME_WIDTH,
    parameter int         MAX_TRIES = 3,
    parameter logic [7:0] MAX_LEVEL = GAME_MAX_LEVEL,
    parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             g_enable,
    input  logic [7:0]       level,
    input  logic             time_f,
    input  logic             guess_b,
    input  logic [WIDTH-1:0] switches,
    output logic [WIDTH-1:0] target,
    output logic             cmp_r,
    output logic             end_f,
    output logic [1:0]       tries_left
`ifdef GUESS_CHECKER_HINT_EN
    ,
    output logic             hint_hi
`endif
);

    gc_state_e        state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             cmp_q, cmp_d;
    logic             end_q, end_d;
    logic [1:0]       tries_q, tries_d;
    logic             g_en_q;
    logic             guess_q;
    logic [7:0]       lfsr_s;
    logic             gen_rise_s;
    logic             guess_rise_s;
    logic             hit_s;
    logic [1:0]       tries_dec_s;
`ifdef GUESS_CHECKER_HINT_EN
    logic             hint_q, hint_d;
`endif

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_s)
    );

    assign gen_rise_s   = g_enable & ~g_en_q;
    assign guess_rise_s = guess_b & ~guess_q;
    assign hit_s        = (switches == target_q);
    assign tries_dec_s  = (tries_q == 2'd0) ? 2'd0 : tries_q - 2'd1;

    // Next-state and output-register logic for the round FSM.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cmp_d    = cmp_q;
        tries_d  = tries_q;
`ifdef GUESS_CHECKER_HINT_EN
        hint_d   = hint_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (gen_rise_s) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                target_d = WIDTH'(lfsr_s & level_mask(level));
                tries_d  = 2'(MAX_TRIES);
                cmp_d    = 1'b0;
`ifdef GUESS_CHECKER_HINT_EN
                hint_d   = 1'b0;
`endif
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                // A guess edge wins over a simultaneous timeout or enable drop.
                if (guess_rise_s) begin
                    cmp_d = hit_s;
                    if (hit_s) begin
                        state_d = S_RESULT;
                    end else begin
                        tries_d = tries_dec_s;
`ifdef GUESS_CHECKER_HINT_EN
                        hint_d  = (switches > target_q);
`endif
                        if ((tries_dec_s == 2'd0) || time_f) begin
                            state_d = S_OVER;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end else if (time_f) begin
                    state_d = S_OVER;
                end else if (!g_enable) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESULT: begin
                if (level >= MAX_LEVEL) begin
                    state_d = S_OVER;
                end else if (!g_enable) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESULT;
                end
            end
            S_OVER: begin
                state_d = S_OVER;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        end_d = end_q | (state_d == S_OVER);
    end

    // State, output and edge-detect registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            cmp_q    <= 1'b0;
            end_q    <= 1'b0;
            tries_q  <= 2'd0;
            g_en_q   <= 1'b0;
            guess_q  <= 1'b0;
`ifdef GUESS_CHECKER_HINT_EN
            hint_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cmp_q    <= cmp_d;
            end_q    <= end_d;
            tries_q  <= tries_d;
            g_en_q   <= g_enable;
            guess_q  <= guess_b;
`ifdef GUESS_CHECKER_HINT_EN
            hint_q   <= hint_d;
`endif
        end
    end

    assign target     = target_q;
    assign cmp_r      = cmp_q;
    assign end_f      = end_q;
    assign tries_left = tries_q;
`ifdef GUESS_CHECKER_HINT_EN
    assign hint_hi    = hint_q;
`endif

endmodule

// File: tb/tb_guess_checker.sv
// Self-checking bench for guess_checker with randomized levels and guesses;
// expected values come from a small rule-level model of the round.
module tb_guess_checker;

    logic       clk = 1'b0;
    logic       rst, g_enable, time_f, guess_b;
    logic [7:0] level, switches, target;
    logic       cmp_r, end_f;
    logic [1:0] tries_left;
`ifdef GUESS_CHECKER_HINT_EN
    logic       hint_hi;
`endif

    int         total = 0;
    int         bad   = 0;
    logic [7:0] m_lfsr;
    logic [7:0] cur_target;

    guess_checker dut (
        .clk        (clk),
        .rst        (rst),
        .g_enable   (g_enable),
        .level      (level),
        .time_f     (time_f),
        .guess_b    (guess_b),
        .switches   (switches),
        .target     (target),
        .cmp_r      (cmp_r),
        .end_f      (end_f),
        .tries_left (tries_left)
`ifdef GUESS_CHECKER_HINT_EN
        ,
        .hint_hi    (hint_hi)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [7:0] mask_for(input int lvl);
        int n;
        n = ((lvl > 7) ? 7 : lvl) + 1;
        return 8'((1 << n) - 1);
    endfunction

    // Reference pseudo-random sequence, restarted by reset.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= lfsr_next(m_lfsr);
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; g_enable = 1'b0; time_f = 1'b0; guess_b = 1'b0;
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    task automatic start_round(input int lvl);
        level    = 8'(lvl);
        g_enable = 1'b1;
        cycle();
        cur_target = m_lfsr & mask_for(lvl);
        cycle();
        total += 3;
        if (target !== cur_target) begin bad++; $display("FAIL load_target: got %h want %h (level %0d)", target, cur_target, lvl); end
        if (tries_left !== 2'd3)   begin bad++; $display("FAIL load_tries: got %0d want 3", tries_left); end
        if (cmp_r !== 1'b0)        begin bad++; $display("FAIL load_cmp: got %b want 0", cmp_r); end
    endtask

    task automatic press(input logic [7:0] val);
        guess_b = 1'b0;
        cycle();
        switches = val;
        guess_b  = 1'b1;
        cycle();
        guess_b = 1'b0;
    endtask

    function automatic logic [7:0] wrong_val();
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        if (v == cur_target) v = v ^ 8'h01;
        return v;
    endfunction

    task automatic test_reset();
        do_reset(2);
        total += 2;
        if ({target, cmp_r, end_f, tries_left} !== 12'd0) begin bad++; $display("FAIL reset_outputs: got %h/%b/%b/%0d want 0", target, cmp_r, end_f, tries_left); end
        if (dut.u_lfsr.q !== 8'hA5) begin bad++; $display("FAIL reset_lfsr: got %h want a5", dut.u_lfsr.q); end
`ifdef GUESS_CHECKER_HINT_EN
        total++;
        if (hint_hi !== 1'b0) begin bad++; $display("FAIL reset_hint: got %b want 0", hint_hi); end
`endif
    endtask

    task automatic test_correct_rounds();
        for (int r = 0; r < 4; r++) begin
            start_round((r == 0) ? 3 : int'($urandom_range(0, 14)));
            press(cur_target);
            total += 3;
            if (cmp_r !== 1'b1)      begin bad++; $display("FAIL hit_cmp: got %b want 1", cmp_r); end
            if (tries_left !== 2'd3) begin bad++; $display("FAIL hit_tries: got %0d want 3", tries_left); end
            if (end_f !== 1'b0)      begin bad++; $display("FAIL hit_end: got %b want 0", end_f); end
            g_enable = 1'b0;
            cycle(); cycle();
            total += 2;
            if (cmp_r !== 1'b1 || target !== cur_target) begin bad++; $display("FAIL hit_hold: got %b/%h want 1/%h", cmp_r, target, cur_target); end
            if (end_f !== 1'b0) begin bad++; $display("FAIL hit_hold_end: got %b want 0", end_f); end
        end
    endtask

    task automatic test_wrong_guesses();
        logic [7:0] v;
        int         exp_tries;
        do_reset(1);
        start_round(int'($urandom_range(0, 14)));
        exp_tries = 3;
        for (int i = 0; i < 3; i++) begin
            v = (i == 0) ? (cur_target ^ 8'h01) : wrong_val();
            press(v);
            exp_tries--;
            total += 3;
            if (tries_left !== 2'(exp_tries)) begin bad++; $display("FAIL miss_tries: got %0d want %0d", tries_left, exp_tries); end
            if (cmp_r !== 1'b0) begin bad++; $display("FAIL miss_cmp: got %b want 0", cmp_r); end
            if (end_f !== (exp_tries == 0)) begin bad++; $display("FAIL miss_end: got %b want %b", end_f, exp_tries == 0); end
`ifdef GUESS_CHECKER_HINT_EN
            total++;
            if (hint_hi !== (v > cur_target)) begin bad++; $display("FAIL miss_hint: got %b want %b", hint_hi, v > cur_target); end
`endif
        end
        press(cur_target);
        total++;
        if ({cmp_r, tries_left, end_f} !== 4'b0_00_1) begin bad++; $display("FAIL over_ignore: got %b/%0d/%b want 0/0/1", cmp_r, tries_left, end_f); end
    endtask

    task automatic test_hold_and_enable_drop();
        do_reset(1);
        start_round(int'($urandom_range(0, 14)));
        switches = wrong_val();
        guess_b  = 1'b1;
        repeat (4) cycle();
        guess_b = 1'b0;
        total++;
        if (tries_left !== 2'd2) begin bad++; $display("FAIL hold_button: got %0d want 2", tries_left); end
        g_enable = 1'b0;
        cycle(); cycle();
        total++;
        if (tries_left !== 2'd2 || target !== cur_target || end_f !== 1'b0) begin bad++; $display("FAIL drop_hold: got %0d/%h/%b want 2/%h/0", tries_left, target, end_f, cur_target); end
        start_round(int'($urandom_range(0, 14)));
    endtask

    task automatic test_timeout();
        do_reset(1);
        start_round(int'($urandom_range(0, 14)));
        time_f = 1'b1;
        cycle();
        time_f = 1'b0;
        total++;
        if (end_f !== 1'b1 || cmp_r !== 1'b0) begin bad++; $display("FAIL timeout: got end %b cmp %b want 1/0", end_f, cmp_r); end
        do_reset(1);
        start_round(int'($urandom_range(0, 14)));
        switches = cur_target; guess_b = 1'b1; time_f = 1'b1;
        cycle();
        guess_b = 1'b0; time_f = 1'b0;
        cycle();
        total++;
        if (cmp_r !== 1'b1 || end_f !== 1'b0) begin bad++; $display("FAIL timeout_hit: got cmp %b end %b want 1/0", cmp_r, end_f); end
        do_reset(1);
        start_round(int'($urandom_range(0, 14)));
        switches = wrong_val(); guess_b = 1'b1; time_f = 1'b1;
        cycle();
        guess_b = 1'b0; time_f = 1'b0;
        total++;
        if (cmp_r !== 1'b0 || end_f !== 1'b1) begin bad++; $display("FAIL timeout_miss: got cmp %b end %b want 0/1", cmp_r, end_f); end
    endtask

    task automatic test_ignored_edges();
        do_reset(1);
        press(8'h00);
        total++;
        if ({target, cmp_r, tries_left} !== 11'd0) begin bad++; $display("FAIL idle_guess: got %h/%b/%0d want 0", target, cmp_r, tries_left); end
        level    = 8'd4;
        g_enable = 1'b1;
        cycle();
        switches = m_lfsr & mask_for(4);
        guess_b  = 1'b1;
        cycle();
        cycle();
        guess_b = 1'b0;
        total++;
        if (cmp_r !== 1'b0 || tries_left !== 2'd3) begin bad++; $display("FAIL load_guess: got %b/%0d want 0/3", cmp_r, tries_left); end
    endtask

    task automatic test_max_level();
        do_reset(1);
        start_round(15);
        press(cur_target);
        total++;
        if (cmp_r !== 1'b1 || end_f !== 1'b0) begin bad++; $display("FAIL max_hit: got cmp %b end %b want 1/0", cmp_r, end_f); end
        cycle();
        total++;
        if (end_f !== 1'b1) begin bad++; $display("FAIL max_end: got %b want 1", end_f); end
        g_enable = 1'b0;
        press(cur_target ^ 8'h80);
        cycle();
        total++;
        if ({cmp_r, end_f, tries_left} !== 4'b1_1_11 || target !== cur_target) begin bad++; $display("FAIL max_ignore: got %b/%b/%0d/%h want 1/1/3/%h", cmp_r, end_f, tries_left, target, cur_target); end
    endtask

    task automatic test_mid_reset();
        for (int s = 0; s < 3; s++) begin
            do_reset(1);
            start_round(int'($urandom_range(0, 14)));
            if (s == 1) press(cur_target);
            if (s == 2) begin time_f = 1'b1; cycle(); time_f = 1'b0; end
            rst = 1'b1; g_enable = 1'b0;
            cycle();
            rst = 1'b0;
            total += 2;
            if ({target, cmp_r, end_f, tries_left} !== 12'd0) begin bad++; $display("FAIL mid_reset %0d: got %h/%b/%b/%0d want 0", s, target, cmp_r, end_f, tries_left); end
            if (dut.u_lfsr.q !== 8'hA5) begin bad++; $display("FAIL mid_reset_lfsr %0d: got %h want a5", s, dut.u_lfsr.q); end
        end
        start_round(7);
    endtask

    initial begin
        rst = 1'b1; g_enable = 1'b0; time_f = 1'b0; guess_b = 1'b0;
        level = 8'd0; switches = 8'd0;
        @(negedge clk);
        test_reset();
        test_correct_rounds();
        test_wrong_guesses();
        test_hold_and_enable_drop();
        test_timeout();
        test_ignored_edges();
        test_max_level();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
